// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: state encodings, default sync marker,
// command codes and the inter-byte timeout length helper.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } parser_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

    localparam logic [7:0] CMD_LCD_WRITE = 8'h01;
    localparam logic [7:0] CMD_LCD_CLEAR = 8'h02;
    localparam logic [7:0] CMD_DHT_READ  = 8'h10;

    function automatic int timeout_cycles(input int clk_freq, input int timeout_us);
        return (clk_freq / 1_000_000) * timeout_us;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout counter: restarts on clear or when disabled, flags the last cycle
// before CYCLES elapse. Expiry is suppressed on a clearing cycle.
module cmd_timeout_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign expire = enable && !clear && (count == W'(CYCLES - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes SYNC/CMD/LEN/PAYLOAD/CHK frames from the UART byte stream and holds each good
// frame until cmd_ready; one byte per cycle. UART_CMD_TIMEOUT_EN adds the inter-byte timeout.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         CLK_FREQ   = 100_000_000,
    parameter int         TIMEOUT_US = 2000,
    parameter int         MAX_LEN    = 8,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           cmd_code,
    output logic [3:0]           cmd_len,
    output logic [8*MAX_LEN-1:0] cmd_payload,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 err_checksum,
    output logic                 err_length,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output logic                 busy,
    output logic [2:0]           debug_state
);

    localparam int TO_CYC = timeout_cycles(CLK_FREQ, TIMEOUT_US);

    if (MAX_LEN < 1 || MAX_LEN > 15 || TO_CYC < 2) begin : g_bad_params
        $error("uart_cmd_parser: MAX_LEN must be 1..15 and the timeout at least 2 cycles");
    end

    parser_state_t state;
    logic [7:0]    chk;
    logic [3:0]    index;
    logic          timed;
    logic          timeout_hit;

    assign timed = (state == ST_CMD) || (state == ST_LEN) ||
                   (state == ST_PAYLOAD) || (state == ST_CHECK);

`ifdef UART_CMD_TIMEOUT_EN
    cmd_timeout_timer #(
        .CYCLES (TO_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid),
        .enable (timed),
        .expire (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            chk          <= '0;
            index        <= '0;
            cmd_code     <= '0;
            cmd_len      <= '0;
            cmd_payload  <= '0;
            cmd_valid    <= 1'b0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            // A byte arriving on the expiry cycle wins over the timeout.
            if (timed && timeout_hit && !rx_valid) begin
                err_timeout <= 1'b1;
                state       <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            chk         <= '0;
                            index       <= '0;
                            cmd_payload <= '0;
                            state       <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (rx_valid) begin
                            cmd_code <= rx_data;
                            chk      <= chk ^ rx_data;
                            state    <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            chk <= chk ^ rx_data;
                            if (rx_data > 8'(MAX_LEN)) begin
                                err_length <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                cmd_len <= rx_data[3:0];
                                state   <= (rx_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_valid) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (index == 4'(i)) cmd_payload[8*i +: 8] <= rx_data;
                            end
                            chk   <= chk ^ rx_data;
                            index <= index + 4'd1;
                            if (index == cmd_len - 4'd1) state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (rx_valid) begin
                            if (rx_data == chk) begin
                                cmd_valid <= 1'b1;
                                state     <= ST_HOLD;
                            end else begin
                                err_checksum <= 1'b1;
                                state        <= ST_IDLE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (rx_valid) err_overrun <= 1'b1;
                        if (cmd_valid && cmd_ready) begin
                            cmd_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign debug_state = state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: good/bad frames, hold/overrun, timeout and reset.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  cmd_code;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_payload;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        err_checksum, err_length, err_timeout, err_overrun;
    logic        busy;
    logic [2:0]  debug_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .CLK_FREQ   (1_000_000),
        .TIMEOUT_US (50),
        .MAX_LEN    (8),
        .SYNC_BYTE  (8'h55)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cmd_code     (cmd_code),
        .cmd_len      (cmd_len),
        .cmd_payload  (cmd_payload),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .err_checksum (err_checksum),
        .err_length   (err_length),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .busy         (busy),
        .debug_state  (debug_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one byte for one cycle; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        int ovr_count;
        int first_to;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_state", 64'(debug_state), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_payload", cmd_payload, 64'd0);
        reset = 1'b1;

        // Good frame, ready already high
        cmd_ready = 1'b1;
        send_byte(8'h55);
        check("t1_state_cmd", 64'(debug_state), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        check("t1_state_payload", 64'(debug_state), 64'd3);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h65);
        check("t1_valid", 64'(cmd_valid), 64'd1);
        check("t1_code", 64'(cmd_code), 64'h01);
        check("t1_len", 64'(cmd_len), 64'd2);
        check("t1_payload", cmd_payload, 64'h0000_0000_0000_CDAB);
        @(negedge clk);
        check("t1_valid_drop", 64'(cmd_valid), 64'd0);
        check("t1_idle", 64'(debug_state), 64'd0);
        check("t1_payload_kept", cmd_payload, 64'h0000_0000_0000_CDAB);

        // Bad checksum
        send_byte(8'h55);
        check("t2_payload_clr", cmd_payload, 64'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h66);
        check("t2_err_chk", 64'(err_checksum), 64'd1);
        check("t2_valid", 64'(cmd_valid), 64'd0);
        check("t2_idle", 64'(debug_state), 64'd0);
        @(negedge clk);
        check("t2_err_chk_pulse", 64'(err_checksum), 64'd0);

        // Over-length, then zero-length frame
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h09);
        check("t3_err_len", 64'(err_length), 64'd1);
        check("t3_idle", 64'(debug_state), 64'd0);
        send_byte(8'h55);
        check("t3_err_len_pulse", 64'(err_length), 64'd0);
        send_byte(8'h10);
        send_byte(8'h00);
        check("t3_state_check", 64'(debug_state), 64'd4);
        send_byte(8'h10);
        check("t3_valid", 64'(cmd_valid), 64'd1);
        check("t3_code", 64'(cmd_code), 64'h10);
        check("t3_len", 64'(cmd_len), 64'd0);
        check("t3_payload", cmd_payload, 64'd0);
        @(negedge clk);
        check("t3_idle2", 64'(debug_state), 64'd0);

        // Hold with backpressure and an overrun byte
        cmd_ready = 1'b0;
        send_byte(8'h55);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h41);
        send_byte(8'h42);
        check("t4_valid", 64'(cmd_valid), 64'd1);
        check("t4_hold", 64'(debug_state), 64'd5);
        ovr_count = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (err_overrun) ovr_count++;
            rx_data  = 8'h55;
            rx_valid = (i == 50);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        if (err_overrun) ovr_count++;
        check("t4_overruns", 64'(ovr_count), 64'd1);
        check("t4_valid_held", 64'(cmd_valid), 64'd1);
        check("t4_code_held", 64'(cmd_code), 64'h02);
        check("t4_len_held", 64'(cmd_len), 64'd1);
        check("t4_payload_held", cmd_payload, 64'h41);
        check("t4_still_hold", 64'(debug_state), 64'd5);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_done", 64'(cmd_valid), 64'd0);
        check("t4_idle", 64'(debug_state), 64'd0);

        // Inter-byte timeout after the CMD byte
        send_byte(8'h55);
        send_byte(8'h01);
        first_to = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (err_timeout && first_to == 0) first_to = k;
        end
`ifdef UART_CMD_TIMEOUT_EN
        check("t5_timeout_cycle", 64'(first_to), 64'd50);
        check("t5_state", 64'(debug_state), 64'd0);
`else
        check("t5_timeout_cycle", 64'(first_to), 64'd0);
        check("t5_state", 64'(debug_state), 64'd2);
`endif

        // Asynchronous reset mid-payload, then recovery
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h55);
        send_byte(8'h03);
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("t6_mid_payload", 64'(debug_state), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_state", 64'(debug_state), 64'd0);
        check("t6_rst_code", 64'(cmd_code), 64'd0);
        check("t6_rst_payload", cmd_payload, 64'd0);
        check("t6_rst_len", 64'(cmd_len), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h7E);
        send_byte(8'h7E);
        check("t6_valid", 64'(cmd_valid), 64'd1);
        check("t6_code", 64'(cmd_code), 64'h01);
        check("t6_len", 64'(cmd_len), 64'd1);
        check("t6_payload", cmd_payload, 64'h7E);
        @(negedge clk);
        check("t6_idle", 64'(debug_state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame decoder and command sequencer between `uart_receiver` and the LCD/DHT11 control logic. It consumes the receiver's byte stream (`rx_data`/`rx_valid`), extracts checksummed command frames, and presents each frame to the downstream controller over a valid/ready handshake. It also flags malformed, truncated and overrun traffic.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `TIMEOUT_US`, default 2000: inter-byte timeout in microseconds. The timeout length is `TO_CYC = (CLK_FREQ/1_000_000)*TIMEOUT_US` cycles.
- `MAX_LEN`, default 8: maximum payload length in bytes. Legal range is 1..15.
- `SYNC_BYTE`, default 8'h55: frame start marker.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `rx_data`  in  8  received byte. Sampled only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle byte strobe.
- `cmd_code`  out  8  command byte of the held frame.
- `cmd_len`  out  4  payload byte count of the held frame.
- `cmd_payload`  out  8*MAX_LEN  payload bytes. Byte 0 is at [7:0]. Unused bytes are 0.
- `cmd_valid`  out  1  frame available.
- `cmd_ready`  in  1  downstream accepts the frame.
- `err_checksum`  out  1  one-cycle pulse: bad checksum.
- `err_length`  out  1  one-cycle pulse: LEN > MAX_LEN.
- `err_timeout`  out  1  one-cycle pulse: frame abandoned on timeout.
- `err_overrun`  out  1  one-cycle pulse: byte dropped while a frame is held.
- `busy`  out  1  high in every state except IDLE.
- `debug_state`  out  3  current state encoding.

## Operation
- Frame format: SYNC, CMD, LEN, PAYLOAD[0..LEN-1], CHK.
- CHK is the XOR of CMD, LEN and all PAYLOAD bytes.
- States: IDLE=0, CMD=1, LEN=2, PAYLOAD=3, CHECK=4, HOLD=5.
- IDLE:
  - A byte equal to SYNC_BYTE moves to CMD. Any other byte is silently ignored.
  - On the move to CMD: the running checksum and byte index clear to 0, and the payload buffer clears to 0.
- CMD: store the byte into `cmd_code`, fold it into the checksum, go to LEN.
- LEN:
  - If the byte > MAX_LEN: pulse `err_length` and return to IDLE.
  - If the byte = 0: store it and go to CHECK.
  - Otherwise: store it and go to PAYLOAD.
  - The byte is folded into the checksum in all cases.
- PAYLOAD:
  - Write the byte to buffer slot `index`, fold it into the checksum, increment `index`.
  - When `index` = LEN-1 is written, go to CHECK.
- CHECK:
  - If the byte equals the running checksum: go to HOLD and assert `cmd_valid`.
  - Otherwise: pulse `err_checksum` and return to IDLE. `cmd_valid` stays 0.
- HOLD:
  - `cmd_code`, `cmd_len` and `cmd_payload` are held stable.
  - Each `rx_valid` pulse drops its byte and pulses `err_overrun`.
  - When `cmd_valid`=1 and `cmd_ready`=1 at a clock edge, the transfer completes. On the next cycle `cmd_valid`=0 and the state is IDLE.
- Frame outputs keep their last values after a transfer. They are rewritten only by the next frame. The payload buffer clear at SYNC updates `cmd_payload`.
- Unknown state encodings go to IDLE.

## Timing
- Reset (asynchronous, active-low): every output goes to 0 and the state goes to IDLE. This applies mid-frame and in HOLD; no error pulse is generated.
- Latency: `cmd_valid` rises on the clock edge that samples the CHK byte's `rx_valid`.
- Error pulses occur on the edge that samples the offending byte.
- `cmd_ready` may be high before `cmd_valid`. The transfer then takes exactly one cycle in HOLD.
- Each incoming byte gets one-cycle processing, so back-to-back bytes on consecutive cycles are accepted.
- Timeout counter:
  - Width is `$clog2(TO_CYC+1)`.
  - It clears on every accepted byte and counts in CMD, LEN, PAYLOAD and CHECK.
  - At count = TO_CYC-1, pulse `err_timeout` and go to IDLE.
  - If `rx_valid` arrives on that same cycle, the byte is processed and the timeout does not fire.
- The timeout is inactive in IDLE and HOLD.

## Configuration
- `UART_CMD_TIMEOUT_EN`:
  - Defined: the inter-byte timeout is implemented as above.
  - Undefined: no counter is built and `err_timeout` is tied to 0. A truncated frame stays pending until more bytes arrive or reset is applied.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - the state encodings,
  - the default SYNC_BYTE,
  - command code constants (LCD_WRITE=8'h01, LCD_CLEAR=8'h02, DHT_READ=8'h10),
  - the function that computes `TO_CYC`.
- One sub-module, `cmd_timeout_timer`: a clear/enable/expire counter. It is instantiated only under `UART_CMD_TIMEOUT_EN`.

## Test plan
- Bytes 55 01 02 AB CD 65 with `cmd_ready`=1 -> `cmd_valid` for 1 cycle, `cmd_code`=01, `cmd_len`=2, `cmd_payload[15:0]`=CDAB, upper bytes 0.
- Bytes 55 01 02 AB CD 66 -> `err_checksum` pulse, `cmd_valid` never asserts, `debug_state` returns to 0.
- Bytes 55 01 09 with MAX_LEN=8 -> `err_length` pulse after the LEN byte. A following valid frame 55 10 00 10 then yields `cmd_code`=10, `cmd_len`=0.
- Valid frame with `cmd_ready`=0 for 100 cycles and byte 55 injected during HOLD -> one `err_overrun` pulse, outputs stable. Raising `cmd_ready` completes the transfer, and the state reaches IDLE on the next cycle.
- With `UART_CMD_TIMEOUT_EN`, CLK_FREQ=1_000_000, TIMEOUT_US=50: send 55 01 then idle -> `err_timeout` exactly 50 cycles after the 01 byte, state goes to IDLE. Without the macro -> no pulse, state stays LEN.
- Drop reset mid-PAYLOAD -> all outputs 0 immediately. After release, a fresh valid frame decodes correctly.
